requant_output_stage: RTL and testbench

Downstream neighbour of the sparse dot-product engine. Accepts one 32-bit accumulator per output channel and adds a per-channel bias. It then applies the per-channel fixed-point scale and rounding right-shift, optional ReLU, and signed saturation to the narrow activation width. Results are buffered in a small FIFO with a valid/ready output toward the activation writer for the next layer. The upstream engine cannot stall, so the pipeline never back-pressures; FIFO overflow is detected and flagged.

---
 rtl/requant_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/requant_output_stage.sv | 96 +++++++++
 tb/tb_requant_output_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared widths, derived datapath types and the round/ReLU/saturate step
// used by the requantisation output stage.
package requant_pkg;

    localparam int ACC_WIDTH   = 32;
    localparam int OUT_WIDTH   = 8;
    localparam int SCALE_WIDTH = 16;
    localparam int SHIFT_WIDTH = 5;

    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int PROD_W = SUM_W + SCALE_WIDTH;

    localparam int OUT_MAX = 2 ** (OUT_WIDTH - 1) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_WIDTH - 1));

    typedef logic signed [ACC_WIDTH-1:0]   acc_t;
    typedef logic signed [SCALE_WIDTH-1:0] scale_t;
    typedef logic        [SHIFT_WIDTH-1:0] shift_t;
    typedef logic signed [SUM_W-1:0]       sum_t;
    typedef logic signed [PROD_W-1:0]      prod_t;
    typedef logic signed [OUT_WIDTH-1:0]   out_t;

    // One guard bit above PROD_W keeps the rounding add exact.
    localparam logic signed [PROD_W:0] SAT_HI = (PROD_W + 1)'(OUT_MAX);
    localparam logic signed [PROD_W:0] SAT_LO = (PROD_W + 1)'(OUT_MIN);

    // Round half toward +inf, optional ReLU, then clamp to the output range.
    function automatic out_t round_sat(input prod_t prod, input shift_t shift, input logic relu);
        logic signed [PROD_W:0] r;
        logic signed [PROD_W:0] half;
        out_t                   res;
        // NOTE: blocking assignments are correct here; a function body is pure
        // combinational evaluation, evaluated top to bottom.
        r    = {prod[PROD_W-1], prod};
        half = '0;
        if (shift != '0) half[shift - 1'b1] = 1'b1;
        r = (r + half) >>> shift;
        if (relu && r[PROD_W]) r = '0;
        if (r > SAT_HI)      res = out_t'(OUT_MAX);
        else if (r < SAT_LO) res = out_t'(OUT_MIN);
        else                 res = out_t'(r);
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle, otherwise it is reported via push_drop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop_fire;
    logic             push_fire;

    assign not_empty = (count != '0);
    assign full      = (count == (AW + 1)'(DEPTH));
    assign pop_fire  = pop && not_empty;
    assign push_fire = push && (!full || pop_fire);
    assign push_drop = push && !push_fire;

    // Head is forced to zero while empty so the output is defined out of reset.
    assign head_data = not_empty ? mem[rd_ptr] : '0;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/requant_output_stage.sv
// Bias, per-channel scale, rounding shift, ReLU and saturation of dot-product
// accumulators, buffered toward the next layer's activation writer.
module requant_output_stage
    import requant_pkg::*;
#(
    parameter int CH_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [ACC_WIDTH-1:0]   in_acc,
    input  logic        [CH_WIDTH-1:0]    in_ch,
    input  logic                          relu_en,
    output logic        [CH_WIDTH-1:0]    param_addr,
    input  logic signed [ACC_WIDTH-1:0]   param_bias,
    input  logic signed [SCALE_WIDTH-1:0] param_scale,
    input  logic        [SHIFT_WIDTH-1:0] param_shift,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic        [CH_WIDTH-1:0]    out_ch,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          busy
);

    localparam int FIFO_W = OUT_WIDTH + CH_WIDTH;

    logic                v0, v1, v2, v3;
    acc_t                acc0;
    logic [CH_WIDTH-1:0] ch0, ch1, ch2, ch3;
    sum_t                sum1;
    scale_t              scale1;
    shift_t              shift1, shift2;
    prod_t               prod2;
    out_t                r3;

    logic [FIFO_W-1:0]   head_data;
    logic                push_drop;

    // Stage valids and the parameter address are the only reset-bearing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0         <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            param_addr <= '0;
        end else begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) param_addr <= in_ch;
        end
    end

    // Parameter RAM data for param_addr arrives in time for the bias stage.
    always_ff @(posedge clk) begin
        acc0   <= in_acc;
        ch0    <= in_ch;
        sum1   <= {acc0[ACC_WIDTH-1], acc0} + {param_bias[ACC_WIDTH-1], param_bias};
        scale1 <= param_scale;
        shift1 <= param_shift;
        ch1    <= ch0;
        prod2  <= PROD_W'(sum1) * PROD_W'(scale1);
        shift2 <= shift1;
        ch2    <= ch1;
        r3     <= round_sat(prod2, shift2, relu_en);
        ch3    <= ch2;
    end

    always_ff @(posedge clk) begin
        if (rst)            overflow <= 1'b0;
        else if (push_drop) overflow <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (v3),
        .push_data ({r3, ch3}),
        .pop       (out_ready),
        .head_data (head_data),
        .not_empty (out_valid),
        .push_drop (push_drop)
    );

    assign out_data = head_data[FIFO_W-1 -: OUT_WIDTH];
    assign out_ch   = head_data[CH_WIDTH-1:0];
    assign busy     = v0 | v1 | v2 | v3 | out_valid;

endmodule

// File: tb/tb_requant_output_stage.sv
// Directed scoreboard bench for requant_output_stage: stimulus queues hand-computed
// results, a negedge monitor pops and compares every accepted output.
module tb_requant_output_stage;
    import requant_pkg::*;

    localparam int CH_WIDTH   = 8;
    localparam int FIFO_DEPTH = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          in_valid;
    logic signed [ACC_WIDTH-1:0]   in_acc;
    logic        [CH_WIDTH-1:0]    in_ch;
    logic                          relu_en;
    logic        [CH_WIDTH-1:0]    param_addr;
    logic signed [ACC_WIDTH-1:0]   param_bias;
    logic signed [SCALE_WIDTH-1:0] param_scale;
    logic        [SHIFT_WIDTH-1:0] param_shift;
    logic                          out_valid;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic        [CH_WIDTH-1:0]    out_ch;
    logic                          out_ready;
    logic                          overflow;
    logic                          busy;

    always #5 clk = ~clk;

    requant_output_stage #(
        .CH_WIDTH   (CH_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_acc      (in_acc),
        .in_ch       (in_ch),
        .relu_en     (relu_en),
        .param_addr  (param_addr),
        .param_bias  (param_bias),
        .param_scale (param_scale),
        .param_shift (param_shift),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    // Parameter RAM model: data for the registered address is visible the cycle after capture.
    logic signed [ACC_WIDTH-1:0]   bias_mem  [256];
    logic signed [SCALE_WIDTH-1:0] scale_mem [256];
    logic        [SHIFT_WIDTH-1:0] shift_mem [256];

    assign param_bias  = bias_mem[param_addr];
    assign param_scale = scale_mem[param_addr];
    assign param_shift = shift_mem[param_addr];

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [CH_WIDTH-1:0]  ch;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_param(input int ch, input int bias, input int scale, input int shift);
        bias_mem[ch]  = ACC_WIDTH'(bias);
        scale_mem[ch] = SCALE_WIDTH'(scale);
        shift_mem[ch] = SHIFT_WIDTH'(shift);
    endtask

    // Present one accumulator; keep=1 queues the hand-computed result.
    task automatic send(input int acc, input int ch, input int exp_data, input bit keep);
        exp_t e;
        in_valid = 1'b1;
        in_acc   = ACC_WIDTH'(acc);
        in_ch    = CH_WIDTH'(ch);
        e.data   = OUT_WIDTH'(exp_data);
        e.ch     = CH_WIDTH'(ch);
        if (keep) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < budget) begin
            tick();
            cyc++;
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got data %0d ch %0d, expected none", out_data, out_ch);
            end else begin
                e = exp_q.pop_front();
                check("out_data", $signed(out_data), $signed(e.data));
                check("out_ch", out_ch, e.ch);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_ch     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) set_param(i, 0, 0, 0);
        repeat (3) tick();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_param_addr", param_addr, 0);
        rst = 1'b0;
        tick();

        // Basic path and 4-cycle latency: (100+28)*3 = 384, (384+2)>>>2 = 96.
        out_ready = 1'b1;
        set_param(1, 28, 3, 2);
        send(100, 1, 96, 1);
        repeat (3) tick();
        check("latency_n3_valid", out_valid, 0);
        check("latency_n3_busy", busy, 1);
        tick();
        check("latency_n4_valid", out_valid, 1);
        wait_drain("drain_basic", 20);

        // Rounding, shift 0, saturation, negative scale, large shift.
        set_param(2, 0, 1, 1);
        set_param(3, 0, 1, 0);
        set_param(4, -10, -2, 3);
        set_param(5, 0, 16384, 20);
        send(5, 2, 3, 1);
        send(-5, 2, -2, 1);
        send(7, 3, 7, 1);
        send(1000, 3, 127, 1);
        send(-500, 3, -128, 1);
        send(50, 4, -10, 1);
        send(1000, 5, 16, 1);
        wait_drain("drain_arith", 30);

        relu_en = 1'b1;
        send(-500, 3, 0, 1);
        send(7, 3, 7, 1);
        wait_drain("drain_relu", 20);
        relu_en = 1'b0;

        // Overflow: six back-to-back with no consumer, only ch 0..3 survive.
        for (int i = 0; i < 6; i++) set_param(i, 0, 1, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(10 + i, i, 10 + i, i < 4);
        repeat (6) tick();
        check("ovf_flag", overflow, 1);
        check("ovf_out_valid", out_valid, 1);
        check("ovf_head_ch", out_ch, 0);
        repeat (2) tick();
        check("ovf_head_hold", out_data, 10);
        pops = n_pop;
        out_ready = 1'b1;
        wait_drain("drain_ovf", 20);
        check("ovf_drain_count", n_pop - pops, 4);
        check("ovf_sticky", overflow, 1);

        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        check("ovf_cleared", overflow, 0);
        rst = 1'b0;
        tick();

        // Full FIFO with a pop on the arrival cycle of the fifth result.
        for (int i = 0; i < 4; i++) send(20 + i, i, 20 + i, 1);
        repeat (6) tick();
        pops = n_pop;
        send(24, 4, 24, 1);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpop_no_ovf", overflow, 0);
        check("fullpop_still_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("drain_fullpop", 20);
        check("fullpop_count", n_pop - pops, 5);
        check("fullpop_no_ovf_end", overflow, 0);

        // Reset with three results in flight and two buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(30 + i, i, 30 + i, 1);
        tick();
        check("pre_rst_busy", busy, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_acc   = 99;
        in_ch    = 9;
        exp_q.delete();
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_param_addr", param_addr, 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pops = n_pop;
        repeat (10) tick();
        check("midrst_no_stale", n_pop - pops, 0);
        check("midrst_idle", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
